clk_en_div: RTL and testbench

CLK_EN_DIV -- requirements
Module: clk_en_div

---
 rtl/clk_en_div_pkg.sv | 13 +
 rtl/clk_en_div.sv | 94 +++++++++
 tb/tb_clk_en_div.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/clk_en_div_pkg.sv
// Shared clocking definitions for the clock-enable divider: FSM states and
// the ratio in effect after reset.
package clk_en_div_pkg;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // 100 MHz / 4 = 25 MHz enable
    localparam int DEFAULT_RESET_DIV = 4;

endpackage

// File: rtl/clk_en_div.sv
// Divide-by-N clock-enable generator on clk_100m. Downstream logic stays on
// clk_100m and qualifies with ce; ce_sq is an observation-only square wave.
module clk_en_div
    import clk_en_div_pkg::*;
#(
    parameter int CNT_WIDTH = 8,
    parameter int RESET_DIV = DEFAULT_RESET_DIV
) (
    input  logic                 clk_100m,
    input  logic                 reset,
    input  logic                 run_en,
    input  logic [CNT_WIDTH-1:0] div_val,
    input  logic                 div_load,
    output logic                 div_ack,
    output logic                 ce,
    output logic                 ce_sq,
    output logic [CNT_WIDTH-1:0] ce_cnt,
    output logic                 busy
);

    state_t               state;
    logic [CNT_WIDTH-1:0] cnt;
    logic [CNT_WIDTH-1:0] n_act;
    logic [CNT_WIDTH-1:0] pend_val;
    logic                 pend;

    logic [CNT_WIDTH-1:0] n_last;
    logic [CNT_WIDTH-1:0] n_half;
    logic [CNT_WIDTH-1:0] load_val;
    logic                 wrap;
    logic                 apply;

    assign n_last   = n_act - CNT_WIDTH'(1);
    assign n_half   = n_act >> 1;
    assign load_val = (div_val == '0) ? CNT_WIDTH'(1) : div_val;
    assign wrap     = (state == ST_RUN) && (cnt == n_last);
    // A new ratio only lands on a period boundary, or immediately when idle.
    assign apply    = pend && ((state == ST_IDLE) || wrap);

    always_ff @(posedge clk_100m) begin
        if (reset) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            n_act    <= CNT_WIDTH'(RESET_DIV);
            pend_val <= '0;
            pend     <= 1'b0;
            ce       <= 1'b0;
            ce_sq    <= 1'b0;
            div_ack  <= 1'b0;
        end else begin
            // Gating with run_en keeps the stop cycle from emitting a last ce.
            ce      <= wrap && run_en;
            ce_sq   <= (state == ST_RUN) && run_en && (cnt < n_half);
            div_ack <= apply;

            if (apply)
                n_act <= pend_val;

            // A load on the apply cycle becomes the next pending ratio.
            if (div_load) begin
                pend_val <= load_val;
                pend     <= 1'b1;
            end else if (apply) begin
                pend     <= 1'b0;
            end

            case (state)
                ST_IDLE: begin
                    cnt <= '0;
                    if (run_en)
                        state <= ST_RUN;
                end
                ST_RUN: begin
                    if (!run_en) begin
                        state <= ST_IDLE;
                        cnt   <= '0;
                    end else if (wrap) begin
                        cnt   <= '0;
                    end else begin
                        cnt   <= cnt + CNT_WIDTH'(1);
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    assign ce_cnt = cnt;
    assign busy   = (state == ST_RUN);

endmodule

// File: tb/tb_clk_en_div.sv
// Bench for clk_en_div: directed vector table, multi-cycle corner sequences,
// and a random run compared against a cycle-level behavioural model.
module tb_clk_en_div;

    localparam int CW = 8;
    localparam int RD = 4;

    logic          clk_100m;
    logic          reset;
    logic          run_en;
    logic [CW-1:0] div_val;
    logic          div_load;
    logic          div_ack;
    logic          ce;
    logic          ce_sq;
    logic [CW-1:0] ce_cnt;
    logic          busy;

    int tests = 0;
    int fails = 0;

    clk_en_div #(.CNT_WIDTH(CW), .RESET_DIV(RD)) dut (
        .clk_100m (clk_100m),
        .reset    (reset),
        .run_en   (run_en),
        .div_val  (div_val),
        .div_load (div_load),
        .div_ack  (div_ack),
        .ce       (ce),
        .ce_sq    (ce_sq),
        .ce_cnt   (ce_cnt),
        .busy     (busy)
    );

    initial clk_100m = 1'b0;
    always #5 clk_100m = ~clk_100m;

    // Behavioural model: phase within the current period, active ratio,
    // and a one-deep "next ratio" mailbox.
    bit m_run, m_pend, e_ce, e_sq, e_ack, m_last, m_take;
    int m_phase, m_n, m_pval;

    always @(posedge clk_100m) begin
        if (reset) begin
            m_run = 0; m_pend = 0; m_phase = 0; m_n = RD; m_pval = 0;
            e_ce = 0; e_sq = 0; e_ack = 0;
        end else begin
            m_last  = m_run && (m_phase == m_n - 1);
            m_take  = m_pend && (!m_run || m_last);
            e_ce    = m_last && run_en;
            e_sq    = m_run && run_en && (m_phase < m_n / 2);
            e_ack   = m_take;
            m_phase = (m_run && run_en && !m_last) ? m_phase + 1 : 0;
            if (m_take) begin
                m_n = m_pval; m_pend = 0;
            end
            if (div_load) begin
                m_pend = 1; m_pval = (div_val == 0) ? 1 : int'(div_val);
            end
            m_run = run_en;
        end
    end

    typedef struct {
        logic rst, run, ld;
        logic [CW-1:0] val;
        logic ce, sq;
        logic [CW-1:0] cnt;
        logic busy, ack;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(logic rst, logic run, logic ld, int val,
                                logic e_c, logic e_s, int cnt, logic bz, logic ak);
        vec_t v;
        v.rst = rst; v.run = run; v.ld = ld; v.val = CW'(val);
        v.ce = e_c; v.sq = e_s; v.cnt = CW'(cnt); v.busy = bz; v.ack = ak;
        tbl.push_back(v);
    endfunction

    function automatic logic [11:0] outs();
        return {ce, ce_sq, ce_cnt, busy, div_ack};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic rst, input logic run, input logic ld, input int val);
        reset = rst; run_en = run; div_load = ld; div_val = CW'(val);
    endtask

    task automatic tick();
        @(posedge clk_100m);
        @(negedge clk_100m);
    endtask

    // Watch outputs for a window: count acks and return spacing of the first two ce pulses.
    task automatic window(input int cycles, output int acks, output int period);
        int first;
        int second;
        first = -1; second = -1; acks = 0;
        drive(0, 1, 0, 0);
        for (int c = 0; c < cycles; c++) begin
            tick();
            if (div_ack) acks++;
            if (ce) begin
                if (first < 0) first = c;
                else if (second < 0) second = c;
            end
        end
        period = (second >= 0) ? second - first : -1;
    endtask

    initial begin
        int acks;
        int per;
        int ce_seen;
        drive(1, 0, 0, 0);
        @(negedge clk_100m);

        // Default ratio, then switch to 10 mid-period.
        add(1,0,0,0,  0,0,0,0,0);
        add(0,1,0,0,  0,0,0,1,0);
        add(0,1,0,0,  0,1,1,1,0);
        add(0,1,0,0,  0,1,2,1,0);
        add(0,1,0,0,  0,0,3,1,0);
        add(0,1,0,0,  1,0,0,1,0);
        add(0,1,0,0,  0,1,1,1,0);
        add(0,1,1,10, 0,1,2,1,0);
        add(0,1,0,0,  0,0,3,1,0);
        add(0,1,0,0,  1,0,0,1,1);
        add(0,1,0,0,  0,1,1,1,0);
        for (int k = 2; k <= 9; k++) add(0,1,0,0, 0, ((k - 1) < 5), k, 1, 0);
        add(0,1,0,0,  1,0,0,1,0);
        add(0,1,0,0,  0,1,1,1,0);
        // Ratio 0 loaded while idle behaves as divide-by-1.
        add(1,0,0,0,  0,0,0,0,0);
        add(0,0,1,0,  0,0,0,0,0);
        add(0,0,0,0,  0,0,0,0,1);
        add(0,1,0,0,  0,0,0,1,0);
        for (int k = 0; k < 4; k++) add(0,1,0,0, 1,0,0,1,0);

        foreach (tbl[i]) begin
            drive(tbl[i].rst, tbl[i].run, tbl[i].ld, int'(tbl[i].val));
            tick();
            check($sformatf("vec%0d", i), 32'(outs()),
                  32'({tbl[i].ce, tbl[i].sq, tbl[i].cnt, tbl[i].busy, tbl[i].ack}));
        end

        // Two loads before one wrap: last wins, single ack.
        drive(1, 0, 0, 0); tick();
        drive(0, 1, 0, 0); tick();
        drive(0, 1, 1, 5); tick();
        drive(0, 1, 1, 7); tick();
        window(30, acks, per);
        check("dbl_ack_count", 32'(acks), 32'd1);
        check("dbl_period", 32'(per), 32'd7);

        // Stop at phase 2.
        drive(1, 0, 0, 0); tick();
        drive(0, 1, 0, 0); tick();
        for (int c = 0; c < 20 && ce_cnt != 2; c++) tick();
        check("stop_at_phase", 32'(ce_cnt), 32'd2);
        drive(0, 0, 0, 0); tick();
        check("stop_outputs", 32'({busy, ce_cnt, ce}), 32'd0);
        ce_seen = 0;
        for (int c = 0; c < 12; c++) begin
            tick();
            if (ce) ce_seen++;
        end
        check("stop_no_ce", 32'(ce_seen), 32'd0);

        // Reset with a ratio pending.
        drive(1, 0, 0, 0); tick();
        drive(0, 1, 0, 0); tick();
        drive(0, 1, 1, 9); tick();
        drive(1, 1, 0, 0); tick();
        check("rst_outputs", 32'(outs()), 32'd0);
        window(12, acks, per);
        check("rst_no_ack", 32'(acks), 32'd0);
        check("rst_period", 32'(per), 32'(RD));

        // Random traffic against the model.
        drive(1, 0, 0, 0); tick();
        for (int c = 0; c < 3000; c++) begin
            reset    = ($urandom % 200) == 0;
            if (($urandom % 16) == 0) run_en = ~run_en;
            div_load = ($urandom % 8) == 0;
            div_val  = CW'($urandom % 7);
            tick();
            check($sformatf("rand%0d", c), 32'(outs()),
                  32'({e_ce, e_sq, CW'(m_phase), m_run, e_ack}));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
